// File: rtl/sim_reset_seq.sv
// Simulation reset sequencer: holds all stage resets low, then releases them
// one by one with a fixed gap, and timestamps cycles once every stage is out.
module sim_reset_seq #(
  parameter int STAGES      = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 4,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_i,
  output logic [STAGES-1:0]    rst_no,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CNT_WIDTH-1:0] cycle_o
);

  localparam int CNT_MAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_RELEASE = 2'd1,
    S_RUN     = 2'd2
  } state_t;

  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic [STAGES-1:0]    r_rst_n;
  logic                 r_busy;
  logic                 r_done;
  logic [CNT_WIDTH-1:0] r_cycle;

  state_t               w_state_nxt;
  logic [CW-1:0]        w_cnt_nxt;
  logic [STAGES-1:0]    w_rst_nxt;
  logic [STAGES-1:0]    w_rst_adv;
  logic [CNT_WIDTH-1:0] w_cycle_nxt;

  // Thermometer advance: releases the lowest stage that is still held.
  always_comb begin
    w_rst_adv    = '0;
    w_rst_adv[0] = 1'b1;
    for (int k = 1; k < STAGES; k++) begin
      w_rst_adv[k] = r_rst_n[k] | r_rst_n[k-1];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rst_nxt   = r_rst_n;
    w_cycle_nxt = r_cycle;
    if (req_i) begin
      w_state_nxt = S_HOLD;
      w_cnt_nxt   = '0;
      w_rst_nxt   = '0;
      w_cycle_nxt = '0;
    end else begin
      case (r_state)
        S_HOLD: begin
          if (r_cnt == HOLD_LAST) begin
            w_rst_nxt   = w_rst_adv;
            w_cnt_nxt   = '0;
            w_state_nxt = (&w_rst_adv) ? S_RUN : S_RELEASE;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        S_RELEASE: begin
          if (r_cnt == GAP_LAST) begin
            w_rst_nxt   = w_rst_adv;
            w_cnt_nxt   = '0;
            w_state_nxt = (&w_rst_adv) ? S_RUN : S_RELEASE;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (r_cycle != '1) begin
            w_cycle_nxt = r_cycle + 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = '0;
          w_rst_nxt   = '0;
          w_cycle_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= S_HOLD;
      r_cnt   <= '0;
      r_rst_n <= '0;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
      r_cycle <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rst_n <= w_rst_nxt;
      r_busy  <= ~&w_rst_nxt;
      r_done  <= &w_rst_nxt;
      r_cycle <= w_cycle_nxt;
    end
  end

  assign rst_no  = r_rst_n;
  assign busy_o  = r_busy;
  assign done_o  = r_done;
  assign cycle_o = r_cycle;

  a_no_x_inputs: assert property (@(posedge clk_i)
    (rst_ni !== 1'b0) |-> !$isunknown({rst_ni, req_i}))
    else $error("sim_reset_seq: X on rst_ni or req_i outside reset");

  a_busy_inv: assert property (@(posedge clk_i) disable iff (rst_ni !== 1'b1)
    busy_o == ~&rst_no);

  a_done_inv: assert property (@(posedge clk_i) disable iff (rst_ni !== 1'b1)
    done_o == &rst_no);

  // A monotonic thermometer code has no set bit above a cleared one.
  a_rst_monotonic: assert property (@(posedge clk_i) disable iff (rst_ni !== 1'b1)
    ((rst_no + STAGES'(1)) & rst_no) == STAGES'(0));

endmodule

// File: tb/tb_sim_reset_seq.sv
// Bench for sim_reset_seq: four parameterisations share one stimulus stream
// and are compared every cycle against an edge-count reference model.
module tb_sim_reset_seq;

  logic        clk;
  logic        rst_n;
  logic        req;

  logic [1:0]  rst0;  logic busy0, done0;  logic [31:0] cyc0;
  logic [0:0]  rst1;  logic busy1, done1;  logic [31:0] cyc1;
  logic [3:0]  rst2;  logic busy2, done2;  logic [31:0] cyc2;
  logic [1:0]  rst3;  logic busy3, done3;  logic [3:0]  cyc3;

  int          n_vec;
  int          n_bad;
  longint      e;

  sim_reset_seq #(.STAGES(2), .HOLD_CYCLES(16), .STAGE_GAP(4), .CNT_WIDTH(32)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req),
    .rst_no(rst0), .busy_o(busy0), .done_o(done0), .cycle_o(cyc0));

  sim_reset_seq #(.STAGES(1), .HOLD_CYCLES(1), .STAGE_GAP(4), .CNT_WIDTH(32)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req),
    .rst_no(rst1), .busy_o(busy1), .done_o(done1), .cycle_o(cyc1));

  sim_reset_seq #(.STAGES(4), .HOLD_CYCLES(16), .STAGE_GAP(1), .CNT_WIDTH(32)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req),
    .rst_no(rst2), .busy_o(busy2), .done_o(done2), .cycle_o(cyc2));

  sim_reset_seq #(.STAGES(2), .HOLD_CYCLES(16), .STAGE_GAP(4), .CNT_WIDTH(4)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req),
    .rst_no(rst3), .busy_o(busy3), .done_o(done3), .cycle_o(cyc3));

  // Clock and initial input levels
  initial begin
    clk   = 1'b0;
    rst_n = 1'b0;
    req   = 1'b0;
  end
  always #5 clk = ~clk;

  // Reference model: outputs follow from the count of edges since the last
  // reset/request edge (e), using the release schedule directly.
  typedef struct {
    longint rst;
    bit     busy;
    bit     done;
    longint cyc;
  } exp_t;

  function automatic exp_t model(longint ev, int s, int h, int g, int w);
    exp_t   r;
    longint n;
    longint e_done;
    longint cmax;
    n = (ev < h) ? 0 : 1 + (ev - h) / g;
    if (n > s) n = s;
    r.rst  = (longint'(1) << n) - 1;
    r.busy = (n != s);
    r.done = (n == s);
    e_done = h + longint'(s - 1) * g;
    cmax   = (longint'(1) << w) - 1;
    if (r.done) r.cyc = ((ev - e_done) > cmax) ? cmax : (ev - e_done);
    else        r.cyc = 0;
    return r;
  endfunction

  // Scoreboard comparison
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (edge count %0d, t=%0t)", name, act, exp, e, $time);
    end
  endtask

  task automatic chk_dut(input string tag, input logic [63:0] r, input logic b,
                         input logic d, input logic [63:0] c,
                         input int s, input int h, input int g, input int w);
    exp_t m;
    m = model(e, s, h, g, w);
    chk({tag, ".rst_no"},  r, m.rst);
    chk({tag, ".busy_o"},  {63'd0, b}, {63'd0, m.busy});
    chk({tag, ".done_o"},  {63'd0, d}, {63'd0, m.done});
    chk({tag, ".cycle_o"}, c, m.cyc);
  endtask

  task automatic check_all();
    chk_dut("d0", 64'(rst0), busy0, done0, 64'(cyc0), 2, 16, 4, 32);
    chk_dut("d1", 64'(rst1), busy1, done1, 64'(cyc1), 1, 1, 4, 32);
    chk_dut("d2", 64'(rst2), busy2, done2, 64'(cyc2), 4, 16, 1, 32);
    chk_dut("d3", 64'(rst3), busy3, done3, 64'(cyc3), 2, 16, 4, 4);
  endtask

  // Driver: one clock edge with the given inputs, then check at the falling edge
  task automatic step(input bit r, input bit q);
    rst_n = r;
    req   = q;
    @(posedge clk);
    if (!r || q) e = 0;
    else         e = e + 1;
    @(negedge clk);
    check_all();
  endtask

  typedef struct {
    bit         rst_n;
    bit         req;
    int         edges;
    logic [1:0] exp_rst;
    bit         exp_busy;
    bit         exp_done;
    longint     exp_cyc;
  } vec_t;

  vec_t tbl[$];

  task automatic add_vec(input bit r, input bit q, input int n, input logic [1:0] er,
                         input bit eb, input bit ed, input longint ec);
    vec_t v;
    v.rst_n = r; v.req = q; v.edges = n;
    v.exp_rst = er; v.exp_busy = eb; v.exp_done = ed; v.exp_cyc = ec;
    tbl.push_back(v);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    e     = 0;

    // Power-up with defaults
    add_vec(0, 0,  5, 2'b00, 1, 0, 0);
    add_vec(1, 0, 15, 2'b00, 1, 0, 0);
    add_vec(1, 0,  1, 2'b01, 1, 0, 0);
    add_vec(1, 0,  3, 2'b01, 1, 0, 0);
    add_vec(1, 0,  1, 2'b11, 0, 1, 0);
    add_vec(1, 0, 10, 2'b11, 0, 1, 10);
    add_vec(1, 0, 40, 2'b11, 0, 1, 50);
    // Re-reset from RUN at cycle_o=50
    add_vec(1, 1,  1, 2'b00, 1, 0, 0);
    add_vec(1, 0, 16, 2'b01, 1, 0, 0);
    add_vec(1, 0,  4, 2'b11, 0, 1, 0);
    // Request while stage 1 is still held (edge 18 of a fresh sequence)
    add_vec(1, 1,  1, 2'b00, 1, 0, 0);
    add_vec(1, 0, 17, 2'b01, 1, 0, 0);
    add_vec(1, 1,  1, 2'b00, 1, 0, 0);
    add_vec(1, 0, 15, 2'b00, 1, 0, 0);
    add_vec(1, 0,  1, 2'b01, 1, 0, 0);
    add_vec(1, 0,  3, 2'b01, 1, 0, 0);
    add_vec(1, 0,  1, 2'b11, 0, 1, 0);
    // Request held high keeps the sequence parked
    add_vec(1, 1,  5, 2'b00, 1, 0, 0);
    add_vec(1, 0, 30, 2'b11, 0, 1, 10);
    // Reset together with request: reset wins, then power-up timing again
    add_vec(0, 1,  3, 2'b00, 1, 0, 0);
    add_vec(1, 0, 15, 2'b00, 1, 0, 0);
    add_vec(1, 0,  1, 2'b01, 1, 0, 0);
    add_vec(1, 0,  4, 2'b11, 0, 1, 0);

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].edges; k++) step(tbl[i].rst_n, tbl[i].req);
      chk($sformatf("tbl%0d.rst_no", i),  64'(rst0),  64'(tbl[i].exp_rst));
      chk($sformatf("tbl%0d.busy_o", i),  64'(busy0), 64'(tbl[i].exp_busy));
      chk($sformatf("tbl%0d.done_o", i),  64'(done0), 64'(tbl[i].exp_done));
      chk($sformatf("tbl%0d.cycle_o", i), 64'(cyc0),  64'(tbl[i].exp_cyc));
    end

    // Parameter corners from a clean reset
    step(0, 0);
    step(0, 0);
    step(1, 0);
    chk("s1h1.rst_no",  64'(rst1),  64'd1);
    chk("s1h1.done_o",  64'(done1), 64'd1);
    chk("s1h1.cycle_o", 64'(cyc1),  64'd0);
    repeat (14) step(1, 0);
    chk("s4g1.rst_no.e15", 64'(rst2), 64'd0);
    for (int k = 0; k < 4; k++) begin
      step(1, 0);
      chk($sformatf("s4g1.rst_no.e%0d", 16 + k), 64'(rst2), (64'd1 << (k + 1)) - 64'd1);
    end
    repeat (21) step(1, 0);
    chk("w4.cycle_o.sat",  64'(cyc3),  64'd15);
    chk("w4.done_o",       64'(done3), 64'd1);
    repeat (5) step(1, 0);
    chk("w4.cycle_o.hold", 64'(cyc3),  64'd15);
    chk("s1h1.cycle_o.e45", 64'(cyc1), 64'd44);

    // Random reset/request traffic against the model
    repeat (400) step($urandom_range(0, 99) >= 3, $urandom_range(0, 99) < 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sim_reset_seq.md
Name: sim_reset_seq

Overview:
- Simulation-side reset sequencer. Consumes the free-running clock from the simulation clock generator.
- Produces staggered, synchronous, active-low resets for the DUT domains: stage 0 is released first, the last stage is released last.
- Reports sequencing status and a cycle timestamp counted from release, for bench scoreboarding.
- Supports a bench-triggered re-reset (req_i) without toggling the global reset.

Parameters:
- STAGES, 2, number of reset outputs; must be >= 1.
- HOLD_CYCLES, 16, cycles rst_no[0] stays low after reset release or request; must be >= 1.
- STAGE_GAP, 4, cycles between consecutive stage releases; must be >= 1.
- CNT_WIDTH, 32, width of cycle_o; must be >= 1.

Ports:
- clk_i  input  1  clock from the simulation clock generator.
- rst_ni  input  1  synchronous active-low reset, sampled on rising clk_i.
- req_i  input  1  re-run the reset sequence, sampled on rising clk_i; level-sensitive.
- rst_no  output  STAGES  active-low stage resets; bit k releases after bit k-1.
- busy_o  output  1  high while any rst_no bit is low.
- done_o  output  1  high while all stages are released (state RUN).
- cycle_o  output  CNT_WIDTH  cycles since the sequence completed; saturating.

Behaviour:
- All outputs are registered, with no combinational input-to-output path.
- Reset, on any edge with rst_ni=0:
  - state=HOLD, internal counter cnt=0.
  - rst_no=all 0, busy_o=1, done_o=0, cycle_o=0.
  - rst_ni overrides req_i.
- State HOLD (counting toward the first release):
  - Each edge with rst_ni=1 increments cnt.
  - The edge where cnt reaches HOLD_CYCLES sets rst_no[0]=1.
  - If STAGES=1, that same edge enters RUN. Otherwise it enters RELEASE with cnt=0.
- State RELEASE (staggered release of stages 1..STAGES-1):
  - Stage k (k>=1) is set to 1 on the edge numbered HOLD_CYCLES + k*STAGE_GAP, counting edges from the first edge with rst_ni=1 (or from the first edge after a request, see below).
  - Released bits stay 1 until the next reset or request.
  - The edge releasing stage STAGES-1 enters RUN.
- State RUN:
  - done_o=1, busy_o=0, rst_no=all 1.
  - cycle_o is 0 on the entry edge and increments by 1 each following edge.
  - cycle_o saturates at 2^CNT_WIDTH-1 and never wraps.
- Request (req_i=1 sampled with rst_ni=1), in any state:
  - The next cycle has rst_no=all 0, busy_o=1, done_o=0, cycle_o=0, state=HOLD, cnt=0.
  - The request edge itself counts as edge 0; the following edge is hold edge 1.
  - Holding req_i high keeps the block in HOLD with cnt=0.
  - A request during HOLD or RELEASE restarts the sequence. Stages already released are re-asserted low.
- Invariants:
  - busy_o == ~&rst_no.
  - done_o == &rst_no.
  - rst_no is monotonic, bit k <= bit k-1 at all times.
  - Default timing: the first edge with rst_ni=1 is edge 1. rst_no[0] rises after edge 16, rst_no[1] and done_o rise after edge 20.
- Simulation only. X on rst_ni or req_i while not in reset is a bench error; the block fires an $error assertion on it.

Test Plan:
- Power-up, defaults: rst_ni=0 for 5 cycles, then 1 -> rst_no=2'b00 through edge 15; 2'b01 after edge 16; 2'b11 and done_o=1 after edge 20; cycle_o=0 at edge 20, 10 at edge 30.
- Re-reset in RUN: req_i=1 for one cycle at cycle_o=50 -> next cycle rst_no=00, done_o=0, cycle_o=0; rst_no=01 after 16 further edges, 11 after 20.
- Request mid-RELEASE: req_i pulse at edge 18, while rst_no=01 -> rst_no=00 next cycle; a full 16/20-edge sequence restarts; no early release of bit 1.
- Reset mid-operation and priority: rst_ni=0 together with req_i=1 during RUN -> outputs at reset values; after rst_ni=1 the timing matches the power-up case exactly.
- Parameter corners: STAGES=1, HOLD_CYCLES=1 -> rst_no=1, done_o=1 and cycle_o=0 after the first edge with rst_ni=1. STAGES=4, STAGE_GAP=1 -> bits release after edges 16,17,18,19.
- Saturation: CNT_WIDTH=4, run 20 cycles in RUN -> cycle_o reaches 15 and holds 15; busy_o/done_o invariants checked by assertion every cycle.
